// File: rtl/sram_controller.sv
// Pipeline-to-SRAM bridge: each 32-bit load/store becomes two 16-bit half accesses (LOW then HIGH).
// Optional address range check is compiled in with `define SRAM_ADDR_CHECK_EN.
module sram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDataOut,
  output logic        sramDataOe,
  input  logic [15:0] sramDataIn,
  output logic        sramWeN
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic        addrError
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);

  state_t      state_reg, state_next;
  logic [3:0]  wait_reg, wait_next;
  logic [16:0] index_reg;
  logic [31:0] data_reg;
  logic        write_reg;
  logic [31:0] read_data_reg;

  logic        req;
  logic [31:0] offset;
  logic [16:0] index;
  logic        last_cycle;
  logic        range_err;
  logic        unused_bits;

  assign req        = memRead | memWrite;
  assign offset     = address - BASE;
  assign index      = offset[18:2];
  assign last_cycle = (wait_reg == LAST_WAIT);
  assign readData   = read_data_reg;

`ifdef SRAM_ADDR_CHECK_EN
  logic err_reg;

  // Below-base addresses wrap to large offsets, but are tested explicitly anyway.
  assign range_err   = (address < BASE) || (offset[31:19] != 13'd0);
  assign unused_bits = ^offset[1:0];
  assign addrError   = err_reg;
`else
  assign range_err   = 1'b0;
  assign unused_bits = ^{offset[31:19], offset[1:0]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      wait_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = range_err ? DONE : LOW;
        end
      end
      LOW: begin
        if (last_cycle) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Counter only runs inside a half and restarts on every state change.
    wait_next = 4'd0;
    if ((state_next == state_reg) && ((state_reg == LOW) || (state_reg == HIGH))) begin
      wait_next = wait_reg + 4'd1;
    end
  end

  // Captured request and read-data assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_reg     <= 17'd0;
      data_reg      <= 32'd0;
      write_reg     <= 1'b0;
      read_data_reg <= 32'd0;
`ifdef SRAM_ADDR_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      if ((state_reg == IDLE) && req) begin
        index_reg <= index;
        data_reg  <= writeData;
        write_reg <= memWrite;
`ifdef SRAM_ADDR_CHECK_EN
        if (range_err) begin
          err_reg <= 1'b1;
          if (!memWrite) begin
            read_data_reg <= 32'd0;
          end
        end
`endif
      end

      if (!write_reg && last_cycle) begin
        if (state_reg == LOW) begin
          read_data_reg[15:0] <= sramDataIn;
        end
        if (state_reg == HIGH) begin
          read_data_reg[31:16] <= sramDataIn;
        end
      end
    end
  end

  // Outputs; the final cycle of each write half releases the strobe so address and data hold.
  always_comb begin
    ready       = 1'b0;
    sramAddr    = 18'd0;
    sramDataOut = 16'd0;
    sramDataOe  = 1'b0;
    sramWeN     = 1'b1;
    case (state_reg)
      IDLE: begin
        ready = ~req;
      end
      LOW: begin
        sramAddr = {index_reg, 1'b0};
        if (write_reg) begin
          sramDataOe  = 1'b1;
          sramDataOut = data_reg[15:0];
          sramWeN     = last_cycle;
        end
      end
      HIGH: begin
        sramAddr = {index_reg, 1'b1};
        if (write_reg) begin
          sramDataOe  = 1'b1;
          sramDataOut = data_reg[31:16];
          sramWeN     = last_cycle;
        end
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule
